// File: rtl/axi_rw_bridge.sv
// axi_rw_bridge: single-outstanding bridge from the arbiter rw_* request port
// to a single-beat AXI4 master (AR/R for reads, AW/W/B for writes).
// Optional feature macro: AXI_BRIDGE_MISALIGN_CHECK_EN -- when defined, a
// misaligned request completes immediately with SLVERR and no AXI traffic.
module axi_rw_bridge #(
  parameter int RW_DATA_WIDTH  = 64,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 64
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      rw_valid,
  output logic                      rw_ready,
  input  logic                      rw_req,
  input  logic [AXI_ADDR_WIDTH-1:0] rw_addr,
  input  logic [1:0]                rw_size,
  input  logic [RW_DATA_WIDTH-1:0]  data_write,
  output logic [RW_DATA_WIDTH-1:0]  data_read,
  output logic [1:0]                rw_resp,
  output logic                      axi_aw_valid,
  input  logic                      axi_aw_ready,
  output logic [AXI_ADDR_WIDTH-1:0] axi_aw_addr,
  output logic [2:0]                axi_aw_size,
  output logic                      axi_w_valid,
  input  logic                      axi_w_ready,
  output logic [AXI_DATA_WIDTH-1:0] axi_w_data,
  output logic [7:0]                axi_w_strb,
  input  logic                      axi_b_valid,
  output logic                      axi_b_ready,
  input  logic [1:0]                axi_b_resp,
  output logic                      axi_ar_valid,
  input  logic                      axi_ar_ready,
  output logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr,
  output logic [2:0]                axi_ar_size,
  input  logic                      axi_r_valid,
  output logic                      axi_r_ready,
  input  logic [AXI_DATA_WIDTH-1:0] axi_r_data,
  input  logic [1:0]                axi_r_resp
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;

  state_t                    state;
  logic [AXI_ADDR_WIDTH-1:0] req_addr;
  logic [1:0]                req_size;
  logic                      aw_done;
  logic                      w_done;
  logic                      aw_hs;
  logic                      w_hs;
  logic                      aw_all;
  logic                      w_all;

  // Byte-enable pattern for an access of the given size, before lane shift.
  function automatic logic [7:0] strb_mask(input logic [1:0] size);
    case (size)
      2'b00:   strb_mask = 8'h01;
      2'b01:   strb_mask = 8'h03;
      2'b10:   strb_mask = 8'h0F;
      default: strb_mask = 8'hFF;
    endcase
  endfunction

  // Bit mask that zero-extends right-aligned read data above the access size.
  function automatic logic [RW_DATA_WIDTH-1:0] data_mask(input logic [1:0] size);
    case (size)
      2'b00:   data_mask = RW_DATA_WIDTH'(64'h0000_0000_0000_00FF);
      2'b01:   data_mask = RW_DATA_WIDTH'(64'h0000_0000_0000_FFFF);
      2'b10:   data_mask = RW_DATA_WIDTH'(64'h0000_0000_FFFF_FFFF);
      default: data_mask = RW_DATA_WIDTH'(64'hFFFF_FFFF_FFFF_FFFF);
    endcase
  endfunction

`ifdef AXI_BRIDGE_MISALIGN_CHECK_EN
  // True when the low address bits are not a multiple of the access size.
  function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size);
    logic [2:0] lsb_mask;
    lsb_mask   = (3'd1 << size) - 3'd1;
    misaligned = (off & lsb_mask) != 3'd0;
  endfunction
`endif

  // Address channels always present the captured request; size is zero-padded.
  assign axi_ar_addr = req_addr;
  assign axi_aw_addr = req_addr;
  assign axi_ar_size = {1'b0, req_size};
  assign axi_aw_size = {1'b0, req_size};

  // Write-channel handshakes this cycle, merged with those already seen.
  assign aw_hs  = axi_aw_valid & axi_aw_ready;
  assign w_hs   = axi_w_valid & axi_w_ready;
  assign aw_all = aw_done | aw_hs;
  assign w_all  = w_done | w_hs;

  // Transaction FSM; every handshake and completion output is registered here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      req_addr     <= '0;
      req_size     <= '0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      rw_ready     <= 1'b0;
      data_read    <= '0;
      rw_resp      <= '0;
      axi_aw_valid <= 1'b0;
      axi_w_valid  <= 1'b0;
      axi_w_data   <= '0;
      axi_w_strb   <= '0;
      axi_b_ready  <= 1'b0;
      axi_ar_valid <= 1'b0;
      axi_r_ready  <= 1'b0;
    end else begin
      rw_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (rw_valid) begin
            req_addr   <= rw_addr;
            req_size   <= rw_size;
            axi_w_data <= data_write << {rw_addr[2:0], 3'b000};
            axi_w_strb <= strb_mask(rw_size) << rw_addr[2:0];
`ifdef AXI_BRIDGE_MISALIGN_CHECK_EN
            if (misaligned(rw_addr[2:0], rw_size)) begin
              state     <= DONE;
              rw_ready  <= 1'b1;
              data_read <= '0;
              rw_resp   <= 2'b10;
            end else
`endif
            if (rw_req) begin
              state        <= WR_REQ;
              axi_aw_valid <= 1'b1;
              axi_w_valid  <= 1'b1;
              aw_done      <= 1'b0;
              w_done       <= 1'b0;
            end else begin
              state        <= RD_ADDR;
              axi_ar_valid <= 1'b1;
            end
          end
        end
        RD_ADDR: begin
          if (axi_ar_ready) begin
            axi_ar_valid <= 1'b0;
            axi_r_ready  <= 1'b1;
            state        <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (axi_r_valid) begin
            axi_r_ready <= 1'b0;
            data_read   <= (axi_r_data >> {req_addr[2:0], 3'b000}) & data_mask(req_size);
            rw_resp     <= axi_r_resp;
            rw_ready    <= 1'b1;
            state       <= DONE;
          end
        end
        WR_REQ: begin
          if (aw_hs) axi_aw_valid <= 1'b0;
          if (w_hs)  axi_w_valid  <= 1'b0;
          aw_done <= aw_all;
          w_done  <= w_all;
          if (aw_all && w_all) begin
            axi_b_ready <= 1'b1;
            state       <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (axi_b_valid) begin
            axi_b_ready <= 1'b0;
            rw_resp     <= axi_b_resp;
            rw_ready    <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rw_bridge.sv
// Self-checking bench for axi_rw_bridge: directed cases plus randomized
// transactions against a cycle-level model of requester and AXI slave.
module tb_axi_rw_bridge;

  logic        clock = 1'b0;
  logic        reset;
  logic        rw_valid, rw_ready, rw_req;
  logic [63:0] rw_addr;
  logic [1:0]  rw_size;
  logic [63:0] data_write, data_read;
  logic [1:0]  rw_resp;
  logic        axi_aw_valid, axi_aw_ready;
  logic [63:0] axi_aw_addr;
  logic [2:0]  axi_aw_size;
  logic        axi_w_valid, axi_w_ready;
  logic [63:0] axi_w_data;
  logic [7:0]  axi_w_strb;
  logic        axi_b_valid, axi_b_ready;
  logic [1:0]  axi_b_resp;
  logic        axi_ar_valid, axi_ar_ready;
  logic [63:0] axi_ar_addr;
  logic [2:0]  axi_ar_size;
  logic        axi_r_valid, axi_r_ready;
  logic [63:0] axi_r_data;
  logic [1:0]  axi_r_resp;

  int n_chk  = 0;
  int n_pass = 0;
  logic [63:0] last_rd = '0;

  axi_rw_bridge dut (
    .clock(clock), .reset(reset),
    .rw_valid(rw_valid), .rw_ready(rw_ready), .rw_req(rw_req),
    .rw_addr(rw_addr), .rw_size(rw_size),
    .data_write(data_write), .data_read(data_read), .rw_resp(rw_resp),
    .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready),
    .axi_aw_addr(axi_aw_addr), .axi_aw_size(axi_aw_size),
    .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready),
    .axi_w_data(axi_w_data), .axi_w_strb(axi_w_strb),
    .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready), .axi_b_resp(axi_b_resp),
    .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready),
    .axi_ar_addr(axi_ar_addr), .axi_ar_size(axi_ar_size),
    .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready),
    .axi_r_data(axi_r_data), .axi_r_resp(axi_r_resp)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  // Reference: right-aligned read data, zero-extended above the access size.
  function automatic logic [63:0] ref_read(input logic [63:0] rd, input logic [2:0] off,
                                           input logic [1:0] size);
    logic [63:0] s;
    int nbytes;
    s = rd >> (8 * int'(off));
    nbytes = 1 << size;
    if (nbytes == 8) return s;
    return s & ((64'd1 << (8 * nbytes)) - 64'd1);
  endfunction

  // Reference: byte strobes of the access, lane-shifted, cut at lane 7.
  function automatic logic [7:0] ref_strb(input logic [2:0] off, input logic [1:0] size);
    logic [15:0] m;
    m = ((16'd1 << (1 << size)) - 16'd1) << off;
    return m[7:0];
  endfunction

  task automatic slave_idle();
    axi_aw_ready = 1'b0; axi_w_ready = 1'b0; axi_b_valid = 1'b0;
    axi_ar_ready = 1'b0; axi_r_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; rw_valid = 1'b0;
    slave_idle();
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  // One request; slave stalls are counted in cycles of ready/valid delay.
  task automatic run_txn(input logic req, input logic [63:0] addr, input logic [1:0] size,
                         input logic [63:0] wd, input logic [63:0] rd, input logic [1:0] resp,
                         input int ars, input int rs, input int aws, input int ws, input int bs);
    int c, exp_lat, arc, awc, wc, ar_hs, aw_hs, w_hs;
    logic done, r_done, b_done, mis;
    logic [63:0] exp_wd;
    mis = 1'b0;
`ifdef AXI_BRIDGE_MISALIGN_CHECK_EN
    mis = (addr[2:0] & ((3'd1 << size) - 3'd1)) != 3'd0;
`endif
    if (mis)       exp_lat = 1;
    else if (!req) exp_lat = 3 + ars + rs;
    else           exp_lat = 3 + ((aws > ws) ? aws : ws) + bs;
    exp_wd = wd << (8 * int'(addr[2:0]));
    rw_valid = 1'b1; rw_req = req; rw_addr = addr; rw_size = size; data_write = wd;
    axi_r_data = rd; axi_r_resp = resp; axi_b_resp = resp;
    slave_idle();
    c = 0; arc = 0; awc = 0; wc = 0; ar_hs = 0; aw_hs = 0; w_hs = 0;
    done = 1'b0; r_done = 1'b0; b_done = 1'b0;
    while (!done && c < 100) begin
      @(negedge clock);
      c++;
      if (axi_ar_valid || axi_aw_valid)
        check("ar_aw_excl", 64'(axi_ar_valid & axi_aw_valid), 64'd0);
      if (axi_ar_valid) begin
        arc++;
        check("ar_addr", axi_ar_addr, addr);
        check("ar_size", 64'(axi_ar_size), 64'(size));
      end
      if (axi_aw_valid) begin
        awc++;
        check("aw_addr", axi_aw_addr, addr);
        check("aw_size", 64'(axi_aw_size), 64'(size));
      end
      if (axi_w_valid) begin
        wc++;
        check("w_data", axi_w_data, exp_wd);
        check("w_strb", 64'(axi_w_strb), 64'(ref_strb(addr[2:0], size)));
      end
      if (rw_ready) begin
        done = 1'b1;
        check("latency", 64'(c), 64'(exp_lat));
        if (mis) begin
          last_rd = '0;
          check("mis_resp", 64'(rw_resp), 64'd2);
          check("mis_data", data_read, 64'd0);
        end else begin
          check("rw_resp", 64'(rw_resp), 64'(resp));
          if (!req) begin
            last_rd = ref_read(rd, addr[2:0], size);
            check("data_read", data_read, last_rd);
          end
        end
        rw_valid = 1'b0;
        slave_idle();
      end else begin
        axi_ar_ready = axi_ar_valid && (c >= 1 + ars);
        if (axi_ar_valid && axi_ar_ready) ar_hs = c;
        axi_r_valid = (ar_hs > 0) && !r_done && (c >= ar_hs + 1 + rs);
        if (axi_r_valid && axi_r_ready) r_done = 1'b1;
        axi_aw_ready = axi_aw_valid && (c >= 1 + aws);
        if (axi_aw_valid && axi_aw_ready) aw_hs = c;
        axi_w_ready = axi_w_valid && (c >= 1 + ws);
        if (axi_w_valid && axi_w_ready) w_hs = c;
        axi_b_valid = (aw_hs > 0) && (w_hs > 0) && !b_done &&
                      (c >= ((aw_hs > w_hs) ? aw_hs : w_hs) + 1 + bs);
        if (axi_b_valid && axi_b_ready) b_done = 1'b1;
      end
    end
    check("completed", 64'(done), 64'd1);
    if (!done) begin
      rw_valid = 1'b0;
      do_reset();
    end else begin
      if (mis)       check("mis_no_axi", 64'(arc + awc + wc), 64'd0);
      else if (!req) check("ar_cycles", 64'(arc), 64'(ars + 1));
      else begin
        check("aw_cycles", 64'(awc), 64'(aws + 1));
        check("w_cycles", 64'(wc), 64'(ws + 1));
      end
      @(negedge clock);
      check("ready_pulse", 64'(rw_ready), 64'd0);
      if (!req || mis) check("data_hold", data_read, last_rd);
    end
  endtask

  initial begin
    rw_req = 1'b0; rw_addr = '0; rw_size = '0; data_write = '0;
    axi_r_data = '0; axi_r_resp = '0; axi_b_resp = '0;
    do_reset();

    check("rst_rw_ready", 64'(rw_ready), 64'd0);
    check("rst_valids", 64'({axi_ar_valid, axi_aw_valid, axi_w_valid}), 64'd0);
    check("rst_readies", 64'({axi_r_ready, axi_b_ready}), 64'd0);
    check("rst_data_read", data_read, 64'd0);
    check("rst_rw_resp", 64'(rw_resp), 64'd0);

    // Directed reads: full width, byte lane 5, long stalls with SLVERR.
    run_txn(1'b0, 64'h8000_0000, 2'b11, 64'h0, 64'h1122_3344_5566_7788, 2'b00, 0, 0, 0, 0, 0);
    run_txn(1'b0, 64'h8000_0005, 2'b00, 64'h0, 64'h1122_3344_5566_7788, 2'b00, 0, 0, 0, 0, 0);
    check("byte5_value", data_read, 64'h33);
    run_txn(1'b0, 64'h8000_0008, 2'b11, 64'h0, 64'hCAFE_F00D_1234_5678, 2'b10, 5, 2, 0, 0, 0);

    // Directed write: halfword in lanes 2-3, AW three cycles late.
    run_txn(1'b1, 64'h8000_0002, 2'b01, 64'hBEEF, 64'h0, 2'b00, 0, 0, 3, 0, 0);

    // Reset while waiting in RD_DATA, then a clean read.
    rw_valid = 1'b1; rw_req = 1'b0; rw_addr = 64'h8000_0010; rw_size = 2'b11;
    slave_idle();
    @(negedge clock);
    axi_ar_ready = 1'b1;
    @(negedge clock);
    axi_ar_ready = 1'b0;
    check("in_rd_data", 64'(axi_r_ready), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; rw_valid = 1'b0;
    check("mid_rst_ctrl", 64'({rw_ready, axi_ar_valid, axi_aw_valid, axi_w_valid,
                               axi_r_ready, axi_b_ready}), 64'd0);
    check("mid_rst_data", data_read, 64'd0);
    check("mid_rst_addr", axi_ar_addr, 64'd0);
    last_rd = '0;
    run_txn(1'b0, 64'h8000_0000, 2'b10, 64'h0, 64'h0123_4567_89AB_CDEF, 2'b00, 0, 0, 0, 0, 0);

    // Misaligned word write.
    run_txn(1'b1, 64'h8000_0002, 2'b10, 64'hDEAD_BEEF, 64'h0, 2'b00, 0, 0, 0, 0, 0);

    // Randomized mix of reads and writes with random stalls.
    for (int i = 0; i < 150; i++) begin
      logic [63:0] a, wd, rd;
      a  = {$urandom, $urandom};
      wd = {$urandom, $urandom};
      rd = {$urandom, $urandom};
      run_txn(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), wd, rd,
              2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
